// File: rtl/fetch_unit.sv
// Program-fetch stage: owns the PC, reads flash, stitches AVR two-word opcodes
// and hands complete instructions to the decoder through a one-entry register.
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16
) (
    input  logic              clk_fm,
    input  logic              rst_fm,
    input  logic              en,
    output logic [ADDR_W-1:0] fm_addr,
    output logic              fm_E,
    input  logic [INST_W-1:0] fm_inst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_ready,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [INST_W-1:0] dec_ext,
    output logic              dec_two_word,
    output logic [ADDR_W-1:0] dec_pc
);

    typedef enum logic [1:0] {IDLE, W1, W2} state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] ext;
        logic              two_word;
        logic [ADDR_W-1:0] pc;
    } dec_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] hold_pc;
    logic [INST_W-1:0] hold;
    dec_t              dec_q;
    logic              free;
    logic              is_two;

    assign fm_addr      = pc;
    assign fm_E         = en & (state != IDLE);
    assign free         = !dec_valid | dec_ready;
    assign dec_inst     = dec_q.inst;
    assign dec_ext      = dec_q.ext;
    assign dec_two_word = dec_q.two_word;
    assign dec_pc       = dec_q.pc;

    // JMP/CALL and LDS/STS carry a second word (address operand)
    assign is_two = ((fm_inst & INST_W'(16'hFE0E)) == INST_W'(16'h940C))
                  | ((fm_inst & INST_W'(16'hFE0E)) == INST_W'(16'h940E))
                  | ((fm_inst & INST_W'(16'hFE0F)) == INST_W'(16'h9000))
                  | ((fm_inst & INST_W'(16'hFE0F)) == INST_W'(16'h9200));

    always_ff @(posedge clk_fm or posedge rst_fm) begin
        if (rst_fm) begin
            state     <= IDLE;
            pc        <= '0;
            hold      <= '0;
            hold_pc   <= '0;
            dec_valid <= 1'b0;
            dec_q     <= '0;
        end else if (redirect) begin
            pc        <= redirect_pc;
            dec_valid <= 1'b0;
            state     <= en ? W1 : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // nothing new is fetched, but a pending entry can still drain
                    if (dec_ready) dec_valid <= 1'b0;
                    if (en) state <= W1;
                end
                W1: begin
                    if (free) begin
                        pc <= pc + ADDR_W'(1);
                        if (is_two) begin
                            hold      <= fm_inst;
                            hold_pc   <= pc;
                            dec_valid <= 1'b0;
                            state     <= W2;
                        end else begin
                            dec_q.inst     <= fm_inst;
                            dec_q.ext      <= '0;
                            dec_q.two_word <= 1'b0;
                            dec_q.pc       <= pc;
                            dec_valid      <= 1'b1;
                            state          <= en ? W1 : IDLE;
                        end
                    end
                end
                W2: begin
                    // second word always completes, regardless of en
                    if (free) begin
                        dec_q.inst     <= hold;
                        dec_q.ext      <= fm_inst;
                        dec_q.two_word <= 1'b1;
                        dec_q.pc       <= hold_pc;
                        dec_valid      <= 1'b1;
                        pc             <= pc + ADDR_W'(1);
                        state          <= W1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset sequence, then a
// randomized run scored against an instruction-stream model of flash.
module tb_fetch_unit;

    logic        clk_fm = 1'b0;
    logic        rst_fm = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  fm_addr;
    logic        fm_E;
    logic [15:0] fm_inst;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [15:0] dec_inst;
    logic [15:0] dec_ext;
    logic        dec_two_word;
    logic [7:0]  dec_pc;

    logic [15:0] mem [256];
    int n_chk = 0;
    int n_fail = 0;

    assign fm_inst = mem[fm_addr];

    fetch_unit #(.ADDR_W(8), .INST_W(16)) dut (
        .clk_fm(clk_fm), .rst_fm(rst_fm), .en(en),
        .fm_addr(fm_addr), .fm_E(fm_E), .fm_inst(fm_inst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .dec_valid(dec_valid),
        .dec_inst(dec_inst), .dec_ext(dec_ext),
        .dec_two_word(dec_two_word), .dec_pc(dec_pc)
    );

    always #5 clk_fm = ~clk_fm;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        img;
        logic        en;
        logic        rdy;
        logic        redir;
        logic [7:0]  rpc;
        logic        v;
        logic [7:0]  pc;
        logic [15:0] inst;
        logic [15:0] ext;
        logic        two;
        logic [7:0]  addr;
        logic        fme;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, logic img, logic e, logic rdy, logic redir,
                                logic [7:0] rpc, logic v, logic [7:0] pc,
                                logic [15:0] inst, logic [15:0] ext, logic two,
                                logic [7:0] addr, logic fme);
        vec_t r;
        r.rst = rst; r.img = img; r.en = e; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
        r.v = v; r.pc = pc; r.inst = inst; r.ext = ext; r.two = two; r.addr = addr; r.fme = fme;
        return r;
    endfunction

    function automatic logic two_word(logic [15:0] w);
        return ((w & 16'hFE0E) == 16'h940C) || ((w & 16'hFE0E) == 16'h940E) ||
               ((w & 16'hFE0F) == 16'h9000) || ((w & 16'hFE0F) == 16'h9200);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_img(input logic img);
        for (int i = 0; i < 256; i++) mem[i] = img ? {8'h02, 8'(i)} : {8'h01, 8'(i)};
        if (img) begin
            mem[3]     = 16'h940C;  // JMP
            mem[4]     = 16'h0010;
            mem[5]     = 16'h940E;  // CALL, abandoned by a redirect
            mem[6]     = 16'h0BAD;
            mem[8'h42] = 16'h0000;
            mem[8'h43] = 16'h0000;
            mem[8'hFF] = 16'h9100;  // LDS straddling the wrap
        end
    endtask

    logic [7:0]  exp_pc;
    logic [15:0] e_inst, e_ext;
    logic        e_two;
    logic        stall_prev;
    logic [40:0] snap;
    int          n_xfer;
    int          r;

    initial begin
        // reset state
        load_img(1'b0);
        #12;
        chk("rst_valid", dec_valid, 0);
        chk("rst_inst", dec_inst, 0);
        chk("rst_ext", dec_ext, 0);
        chk("rst_two", dec_two_word, 0);
        chk("rst_pc", dec_pc, 0);
        chk("rst_addr", fm_addr, 0);
        chk("rst_fmE", fm_E, 0);

        //        rst img en rdy rd rpc    v  pc     inst      ext       two addr  fme
        vt.push_back(mk(1, 0, 1, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 16'h0000, 0, 8'h00, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 8'h00, 16'h0100, 16'h0000, 0, 8'h01, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 8'h01, 16'h0101, 16'h0000, 0, 8'h02, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 8'h02, 16'h0102, 16'h0000, 0, 8'h03, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 8'h03, 16'h0103, 16'h0000, 0, 8'h04, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 8'h04, 16'h0104, 16'h0000, 0, 8'h05, 1));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 1, 8'h04, 16'h0104, 16'h0000, 0, 8'h05, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 8'h05, 16'h0105, 16'h0000, 0, 8'h06, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 8'h06, 16'h0106, 16'h0000, 0, 8'h07, 1));
        vt.push_back(mk(1, 1, 1, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 16'h0000, 0, 8'h00, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h00, 16'h0200, 16'h0000, 0, 8'h01, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h01, 16'h0201, 16'h0000, 0, 8'h02, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h02, 16'h0202, 16'h0000, 0, 8'h03, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 16'h0000, 0, 8'h04, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h03, 16'h940C, 16'h0010, 1, 8'h05, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 16'h0000, 0, 8'h06, 1));
        vt.push_back(mk(0, 1, 1, 1, 1, 8'h40, 0, 8'h00, 16'h0000, 16'h0000, 0, 8'h40, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h40, 16'h0240, 16'h0000, 0, 8'h41, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h41, 16'h0241, 16'h0000, 0, 8'h42, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h42, 16'h0000, 16'h0000, 0, 8'h43, 1));
        vt.push_back(mk(0, 1, 0, 1, 0, 8'h00, 1, 8'h43, 16'h0000, 16'h0000, 0, 8'h44, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 8'h00, 1, 8'h43, 16'h0000, 16'h0000, 0, 8'h44, 0));
        vt.push_back(mk(0, 1, 1, 1, 1, 8'hFF, 0, 8'h00, 16'h0000, 16'h0000, 0, 8'hFF, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 16'h0000, 16'h0000, 0, 8'h00, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'hFF, 16'h9100, 16'h0200, 1, 8'h01, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'h01, 16'h0201, 16'h0000, 0, 8'h02, 1));

        @(negedge clk_fm);
        foreach (vt[i]) begin
            if (vt[i].rst) begin
                rst_fm = 1'b1; en = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
                load_img(vt[i].img);
                @(negedge clk_fm);
                rst_fm = 1'b0;
            end
            en = vt[i].en; dec_ready = vt[i].rdy;
            redirect = vt[i].redir; redirect_pc = vt[i].rpc;
            @(negedge clk_fm);
            chk($sformatf("r%0d_valid", i), dec_valid, vt[i].v);
            chk($sformatf("r%0d_addr", i), fm_addr, vt[i].addr);
            chk($sformatf("r%0d_fmE", i), fm_E, vt[i].fme);
            if (vt[i].v) begin
                chk($sformatf("r%0d_pc", i), dec_pc, vt[i].pc);
                chk($sformatf("r%0d_inst", i), dec_inst, vt[i].inst);
                chk($sformatf("r%0d_ext", i), dec_ext, vt[i].ext);
                chk($sformatf("r%0d_two", i), dec_two_word, vt[i].two);
            end
        end

        // async reset in the middle of a stall with a pending entry
        redirect = 1'b0; dec_ready = 1'b0;
        #2 rst_fm = 1'b1;
        #1;
        chk("arst_valid", dec_valid, 0);
        chk("arst_addr", fm_addr, 0);
        chk("arst_pc", dec_pc, 0);
        @(negedge clk_fm);
        rst_fm = 1'b0; en = 1'b1; dec_ready = 1'b1;
        @(negedge clk_fm);
        chk("arst_idle_valid", dec_valid, 0);
        chk("arst_idle_addr", fm_addr, 0);
        @(negedge clk_fm);
        chk("arst_first_valid", dec_valid, 1);
        chk("arst_first_pc", dec_pc, 0);
        chk("arst_first_inst", dec_inst, 16'h0200);

        // randomized run against the instruction-stream model
        rst_fm = 1'b1; en = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      mem[i] = 16'h940C | (16'($urandom) & 16'h01F3);
            else if (r == 1) mem[i] = 16'h9000 | (16'($urandom) & 16'h03F0);
            else             mem[i] = 16'($urandom);
        end
        @(negedge clk_fm);
        rst_fm = 1'b0;
        exp_pc = 8'h00; stall_prev = 1'b0; snap = '0; n_xfer = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_fm);
            if (stall_prev) begin
                chk("rnd_stall_valid", dec_valid, 1);
                chk("rnd_stall_fields", {dec_inst, dec_ext, dec_pc, dec_two_word}, snap);
            end
            en = ($urandom_range(0, 9) != 0);
            dec_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 29) == 0);
            redirect_pc = 8'($urandom);
            stall_prev = dec_valid && !dec_ready && !redirect;
            snap = {dec_inst, dec_ext, dec_pc, dec_two_word};
            if (dec_valid && dec_ready) begin
                e_inst = mem[exp_pc];
                e_two  = two_word(e_inst);
                e_ext  = e_two ? mem[8'(exp_pc + 8'd1)] : 16'h0000;
                chk("rnd_pc", dec_pc, exp_pc);
                chk("rnd_inst", dec_inst, e_inst);
                chk("rnd_ext", dec_ext, e_ext);
                chk("rnd_two", dec_two_word, e_two);
                exp_pc = exp_pc + (e_two ? 8'd2 : 8'd1);
                n_xfer++;
            end
            if (redirect) exp_pc = redirect_pc;
        end
        chk("rnd_progress", (n_xfer > 500) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
